// File: rtl/pe_seq_pkg.sv
// Shared types and frame helpers for the reversible_pe host sequencer.
package pe_seq_pkg;

    localparam int SEQ_DW = 18;
    localparam int SEQ_AW = 4;
    localparam int SEQ_FW = SEQ_DW + SEQ_AW + 3;

    localparam logic [1:0] OP_WR = 2'b10;
    localparam logic [1:0] OP_RD = 2'b01;

    typedef enum logic [3:0] {
        IDLE,
        WR_ISS,
        WR_WAIT,
        KICK_ISS,
        KICK_WAIT,
        DRAIN,
        RD_ISS,
        RD_WAIT,
        FIN
    } state_e;

    function automatic logic [SEQ_FW-1:0] mk_frame(input logic [1:0]        op,
                                                   input logic [SEQ_AW-1:0] addr,
                                                   input logic [SEQ_DW-1:0] data);
        return {op, addr, 1'b0, data};
    endfunction

endpackage

// File: rtl/pe_seq_buf.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module pe_seq_buf
    import pe_seq_pkg::*;
#(
    parameter int DW    = SEQ_DW,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_host_sequencer.sv
// Runs one reversible_pe job over host_spi: write operands, kick, drain, read results.
module pe_host_sequencer
    import pe_seq_pkg::*;
#(
    parameter int            DW        = SEQ_DW,
    parameter int            AW        = SEQ_AW,
    parameter int            DEPTH     = 8,
    parameter int            KICK_ADDR = 0,
    parameter logic [DW-1:0] KICK_DATA = 'h20000,
    parameter int            TIMEOUT   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   op_wr_addr,
    input  logic [DW-1:0]              op_wr_data,
    input  logic [$clog2(DEPTH+1)-1:0] num_words,
    input  logic [15:0]                wait_cycles,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic [$clog2(DEPTH)-1:0]   res_rd_addr,
    output logic [DW-1:0]              res_rd_data,
    output logic                       spi_start,
    output logic [DW+AW+2:0]           spi_tx_data,
    input  logic                       spi_complete,
    input  logic [DW-1:0]              spi_rx_data,
    input  logic                       spi_rx_valid
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);

    state_e          state, state_n;
    logic [IW-1:0]   idx;
    logic [NW-1:0]   num_lat;
    logic [15:0]     wait_lat;
    logic [15:0]     drain_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [DW-1:0]   op_rd_data;
    logic            go_acc;
    logic            last;
    logic            wait_st;
    logic            wait_evt;
    logic            tmo_hit;
    logic            op_we;
    logic            res_we;

    // A go landing in the done cycle is dropped so back-to-back pulses never chain jobs.
    assign go_acc   = go && (state == IDLE) && !done;
    assign last     = (NW'(idx) == (num_lat - NW'(1)));
    assign wait_st  = (state == WR_WAIT) || (state == KICK_WAIT) || (state == RD_WAIT);
    assign wait_evt = (state == RD_WAIT) ? spi_rx_valid : spi_complete;
    assign tmo_hit  = wait_st && !wait_evt && (tmo_cnt == TW'(TIMEOUT - 1));
    assign op_we    = op_wr_en && (state == IDLE);
    assign res_we   = (state == RD_WAIT) && spi_rx_valid;

    pe_seq_buf #(.DW(DW), .DEPTH(DEPTH)) u_op_buf (
        .clk     (clk),
        .wr_en   (op_we),
        .wr_addr (op_wr_addr),
        .wr_data (op_wr_data),
        .rd_addr (idx),
        .rd_data (op_rd_data)
    );

    pe_seq_buf #(.DW(DW), .DEPTH(DEPTH)) u_res_buf (
        .clk     (clk),
        .wr_en   (res_we),
        .wr_addr (idx),
        .wr_data (spi_rx_data),
        .rd_addr (res_rd_addr),
        .rd_data (res_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (go_acc) state_n = (num_words == '0) ? FIN : WR_ISS;
            WR_ISS:    state_n = WR_WAIT;
            WR_WAIT: begin
                if (spi_complete) state_n = last ? KICK_ISS : WR_ISS;
                else if (tmo_hit) state_n = FIN;
            end
            KICK_ISS:  state_n = KICK_WAIT;
            KICK_WAIT: begin
                if (spi_complete) state_n = (wait_lat == 16'd0) ? RD_ISS : DRAIN;
                else if (tmo_hit) state_n = FIN;
            end
            DRAIN:     if (drain_cnt == 16'd1) state_n = RD_ISS;
            RD_ISS:    state_n = RD_WAIT;
            RD_WAIT: begin
                if (spi_rx_valid) state_n = last ? FIN : RD_ISS;
                else if (tmo_hit) state_n = FIN;
            end
            FIN:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // The frame is a pure function of state and idx, so it stays put for the whole frame.
    always_comb begin
        spi_start   = 1'b0;
        spi_tx_data = '0;
        case (state)
            WR_ISS, WR_WAIT:     spi_tx_data = mk_frame(OP_WR, AW'(idx), op_rd_data);
            KICK_ISS, KICK_WAIT: spi_tx_data = mk_frame(OP_WR, AW'(KICK_ADDR), KICK_DATA);
            RD_ISS, RD_WAIT:     spi_tx_data = mk_frame(OP_RD, AW'(idx), '0);
            default:             spi_tx_data = '0;
        endcase
        spi_start = (state == WR_ISS) || (state == KICK_ISS) || (state == RD_ISS);
    end

    always_ff @(posedge clk) begin
        if (go_acc) begin
            num_lat  <= num_words;
            wait_lat <= wait_cycles;
            idx      <= '0;
        end
        case (state)
            WR_WAIT:   if (spi_complete) idx <= last ? '0 : idx + IW'(1);
            RD_WAIT:   if (spi_rx_valid) idx <= idx + IW'(1);
            KICK_WAIT: if (spi_complete) drain_cnt <= wait_lat;
            DRAIN:     drain_cnt <= drain_cnt - 16'd1;
            default:   ;
        endcase
        if (spi_start) begin
            tmo_cnt <= '0;
        end else if (wait_st) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (go_acc) begin
                busy <= 1'b1;
            end else if (state == FIN) begin
                busy <= 1'b0;
            end
            if (go_acc) begin
                err <= 1'b0;
            end else if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_host_sequencer.sv
// Bench for pe_host_sequencer: behavioural host_spi/PE model plus a frame scoreboard.
module tb_pe_host_sequencer;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 8;
    localparam int FW    = DW + AW + 3;
    localparam int TMO   = 64;
    localparam logic [FW-1:0] KICK_FRAME = 25'h1020000;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_wr_en;
    logic [2:0]    op_wr_addr;
    logic [DW-1:0] op_wr_data;
    logic [3:0]    num_words;
    logic [15:0]   wait_cycles;
    logic          go;
    logic          busy, done, err;
    logic [2:0]    res_rd_addr;
    logic [DW-1:0] res_rd_data;
    logic          spi_start;
    logic [FW-1:0] spi_tx_data;
    logic          spi_complete = 1'b0;
    logic [DW-1:0] spi_rx_data  = '0;
    logic          spi_rx_valid = 1'b0;

    always #5 clk = ~clk;

    pe_host_sequencer #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_wr_en     (op_wr_en),
        .op_wr_addr   (op_wr_addr),
        .op_wr_data   (op_wr_data),
        .num_words    (num_words),
        .wait_cycles  (wait_cycles),
        .go           (go),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .res_rd_addr  (res_rd_addr),
        .res_rd_data  (res_rd_data),
        .spi_start    (spi_start),
        .spi_tx_data  (spi_tx_data),
        .spi_complete (spi_complete),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid)
    );

    // Reversible PE stand-in: a read returns the stored word with its halves swapped.
    function automatic logic [DW-1:0] pe_xform(input logic [DW-1:0] d);
        return {d[8:0], d[17:9]};
    endfunction

    function automatic logic [FW-1:0] mkf(input logic [1:0] op, input int a, input logic [DW-1:0] d);
        return {op, 4'(a), 1'b0, d};
    endfunction

    int            cyc = 0;
    int            frame_no = 0;
    int            withhold_idx;
    int            lat = 0;
    logic          pend = 1'b0;
    logic          skip = 1'b0;
    logic [FW-1:0] cur = '0;
    logic [DW-1:0] pe_mem [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        spi_complete <= 1'b0;
        spi_rx_valid <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (spi_start) begin
            pend     <= 1'b1;
            cur      <= spi_tx_data;
            lat      <= 3;
            skip     <= (frame_no == withhold_idx);
            frame_no <= frame_no + 1;
        end else if (pend) begin
            if (lat > 0) begin
                lat <= lat - 1;
            end else begin
                pend <= 1'b0;
                if (!skip) begin
                    if (cur[24:23] == 2'b10) begin
                        spi_complete <= 1'b1;
                        if (cur != KICK_FRAME) pe_mem[cur[22:19]] <= cur[17:0];
                    end else begin
                        spi_rx_valid <= 1'b1;
                        spi_rx_data  <= pe_xform(pe_mem[cur[22:19]]);
                    end
                end
            end
        end
    end

    int            total = 0;
    int            bad = 0;
    logic [FW-1:0] exp_q [$];
    logic [DW-1:0] exp_op [DEPTH];
    int            done_cnt = 0;
    int            start_cnt = 0;
    int            last_cmpl_cyc = 0;
    int            first_rd_gap = -1;
    int            first_start_cyc = -1;
    int            go_cyc = 0;
    logic          arm_first = 1'b0;
    logic          rd_armed = 1'b0;
    logic          kick_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (spi_complete) last_cmpl_cyc = cyc;
            if (pend && !spi_start) chk("tx_stable", 32'(spi_tx_data), 32'(cur));
            if (spi_start) begin
                start_cnt++;
                chk("one_outstanding", 32'(pend), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got %0h expected no frame", spi_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", 32'(spi_tx_data), 32'(e));
                end
                if (arm_first) begin
                    first_start_cyc = cyc;
                    arm_first = 1'b0;
                end
                if (spi_tx_data == KICK_FRAME) begin
                    kick_seen = 1'b1;
                    rd_armed  = 1'b1;
                end else if (spi_tx_data[24:23] == 2'b01 && rd_armed) begin
                    first_rd_gap = cyc - last_cmpl_cyc;
                    rd_armed = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input int i, input logic [DW-1:0] d);
        op_wr_en   = 1'b1;
        op_wr_addr = 3'(i);
        op_wr_data = d;
        exp_op[i]  = d;
        step();
        op_wr_en   = 1'b0;
    endtask

    task automatic push_job(input int num);
        for (int i = 0; i < num; i++) exp_q.push_back(mkf(2'b10, i, exp_op[i]));
        exp_q.push_back(KICK_FRAME);
        for (int i = 0; i < num; i++) exp_q.push_back(mkf(2'b01, i, '0));
    endtask

    task automatic go_job(input int num, input int wt, output int d0);
        d0          = done_cnt;
        num_words   = 4'(num);
        wait_cycles = 16'(wt);
        go          = 1'b1;
        go_cyc      = cyc;
        arm_first   = 1'b1;
        step();
        go          = 1'b0;
    endtask

    task automatic finish_job(input int d0, input logic exp_err, input string nm);
        int c = 0;
        while (done_cnt == d0 && c < 3000) begin
            step();
            c++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (8) step();
        chk({nm, "_done_once"}, 32'(done_cnt - d0), 1);
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
        chk({nm, "_busy_end"}, 32'(busy), 0);
        chk({nm, "_frames_left"}, 32'(exp_q.size()), 0);
    endtask

    task automatic chk_results(input int num, input string nm);
        for (int i = 0; i < num; i++) begin
            res_rd_addr = 3'(i);
            #1;
            chk({nm, "_res"}, 32'(res_rd_data), 32'(pe_xform(exp_op[i])));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int c;
        int s0;
        rst = 1'b1; go = 1'b0; op_wr_en = 1'b0; op_wr_addr = '0; op_wr_data = '0;
        num_words = '0; wait_cycles = '0; res_rd_addr = '0; withhold_idx = -1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_spi_start", 32'(spi_start), 0);
        chk("rst_tx_data", 32'(spi_tx_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Basic eight-word job
        for (int i = 0; i < 8; i++) load_op(i, 18'h10101 + 18'(i));
        push_job(8);
        go_job(8, 100, d0);
        finish_job(d0, 1'b0, "basic");
        chk("basic_go_to_start", 32'(first_start_cyc - go_cyc), 1);
        chk("basic_drain_gap", 32'(first_rd_gap), 101);
        chk_results(8, "basic");

        // Empty job
        s0 = start_cnt;
        go_job(0, 50, d0);
        @(negedge clk);
        chk("num0_busy_t1", 32'(busy), 1);
        chk("num0_done_t1", 32'(done), 0);
        step();
        @(negedge clk);
        chk("num0_busy_t2", 32'(busy), 0);
        chk("num0_done_t2", 32'(done), 1);
        step();
        @(negedge clk);
        chk("num0_done_t3", 32'(done), 0);
        finish_job(d0, 1'b0, "num0");
        chk("num0_no_frames", 32'(start_cnt - s0), 0);

        // Single word, no drain
        load_op(0, 18'h0ABCD);
        s0 = start_cnt;
        push_job(1);
        go_job(1, 0, d0);
        finish_job(d0, 1'b0, "one");
        chk("one_frame_count", 32'(start_cnt - s0), 3);
        chk("one_drain_gap", 32'(first_rd_gap), 1);
        chk_results(1, "one");

        // Third frame never completes
        withhold_idx = frame_no + 2;
        for (int i = 0; i < 3; i++) exp_q.push_back(mkf(2'b10, i, exp_op[i]));
        go_job(8, 10, d0);
        finish_job(d0, 1'b1, "tmo");
        withhold_idx = -1;
        go_job(0, 0, d0);
        @(negedge clk);
        chk("tmo_err_cleared", 32'(err), 0);
        finish_job(d0, 1'b0, "tmo_clr");

        // go and operand writes while busy
        push_job(4);
        go_job(4, 20, d0);
        step();
        step();
        op_wr_en = 1'b1; op_wr_addr = 3'd3; op_wr_data = 18'h3FFFF;
        go = 1'b1; num_words = 4'd8;
        step();
        op_wr_en = 1'b0; go = 1'b0;
        finish_job(d0, 1'b0, "prot");
        chk_results(4, "prot");

        // Reset during DRAIN, then a clean job
        load_op(0, 18'h01234);
        load_op(1, 18'h05678);
        push_job(2);
        kick_seen = 1'b0;
        go_job(2, 200, d0);
        c = 0;
        while (!kick_seen && c < 200) begin
            step();
            c++;
        end
        chk("rstd_kick_seen", 32'(kick_seen), 1);
        repeat (20) step();
        chk("rstd_busy_before", 32'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        step();
        @(negedge clk);
        chk("rstd_busy", 32'(busy), 0);
        chk("rstd_spi_start", 32'(spi_start), 0);
        chk("rstd_tx_data", 32'(spi_tx_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) load_op(i, 18'h20001 + 18'(i * 16));
        push_job(8);
        go_job(8, 5, d0);
        finish_job(d0, 1'b0, "clean");
        chk("clean_drain_gap", 32'(first_rd_gap), 6);
        chk_results(8, "clean");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
